sram_l1_req_ctrl: RTL and testbench

Request sequencer upstream of the L1 SRAM wrapper (`sram_wrap_l1`). It accepts valid/ready read and write requests from the core side and buffers them in a small FIFO. It drives the wrapper's active-low `csb`/`we` protocol with correct setup, hold and gap timing. Reads wait for `data_ready`, and the read data comes back on a valid/ready response port.

---
 rtl/sram_l1_req_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_l1_req_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_l1_req_ctrl.sv
// Request sequencer in front of the L1 SRAM wrapper: request FIFO, csb/we timing FSM, read response register.
// Optional read-wait timeout enabled by defining SRAM_L1_REQ_TIMEOUT_EN.
module sram_l1_req_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_HOLD    = 2,
    parameter int TIMEOUT    = 80
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic                  sram_csb,
    output logic                  sram_we,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    input  logic                  sram_data_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int HW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WR_HOLD < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("sram_l1_req_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WR, S_RD, S_GAP} state_t;

    // FIFO storage
    logic                  r_fifo_wr    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
    logic [NUM_WMASKS-1:0] r_fifo_wmask [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;

    state_t                r_state;
    logic                  r_csb, r_we, r_is_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic [HW-1:0]         r_hcnt;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic w_full, w_empty, w_push, w_pop, w_head_wr;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && !w_full;
    assign w_head_wr = r_fifo_wr[r_rptr];
    // A head read waits for the previous response to drain; writes behind it stay queued.
    assign w_pop     = (r_state == S_IDLE) && !w_empty && (w_head_wr || !r_rsp_valid);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr[r_wptr]    <= req_wr;
            r_fifo_addr[r_wptr]  <= req_addr;
            r_fifo_wdata[r_wptr] <= req_wdata;
            r_fifo_wmask[r_wptr] <= req_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SRAM_L1_REQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] r_tcnt;
    logic          r_rsp_err;
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_csb       <= 1'b1;
            r_we        <= 1'b1;
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_wmask     <= '0;
            r_hcnt      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef SRAM_L1_REQ_TIMEOUT_EN
            r_tcnt      <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_is_wr <= w_head_wr;
                        r_addr  <= r_fifo_addr[r_rptr];
                        r_din   <= r_fifo_wdata[r_rptr];
                        r_wmask <= r_fifo_wmask[r_rptr];
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_csb  <= 1'b0;
                    r_we   <= !r_is_wr;
                    r_hcnt <= '0;
`ifdef SRAM_L1_REQ_TIMEOUT_EN
                    r_tcnt <= '0;
`endif
                    r_state <= r_is_wr ? S_WR : S_RD;
                end
                S_WR: begin
                    if (r_hcnt == HW'(WR_HOLD - 1)) begin
                        r_csb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
                S_RD: begin
                    if (sram_data_ready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= sram_dout;
`ifdef SRAM_L1_REQ_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_csb       <= 1'b1;
                        r_state     <= S_GAP;
                    end
`ifdef SRAM_L1_REQ_TIMEOUT_EN
                    else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_csb       <= 1'b1;
                        r_state     <= S_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
`endif
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_csb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = !w_full;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign sram_addr  = r_addr;
    assign sram_din   = r_din;
    assign sram_wmask = r_wmask;
    assign sram_csb   = r_csb;
    assign sram_we    = r_we;

endmodule

// File: tb/tb_sram_l1_req_ctrl.sv
// Scoreboard bench for sram_l1_req_ctrl with a behavioural stand-in for the L1 SRAM wrapper.
module tb_sram_l1_req_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_wr = 0;
    logic        req_ready;
    logic [8:0]  req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic [3:0]  req_wmask = 0;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1;
    logic [31:0] rsp_rdata;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;
    logic [3:0]  sram_wmask;
    logic        sram_csb, sram_we, sram_data_ready;

    int n_cmp = 0, n_bad = 0;

    sram_l1_req_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_WMASKS(4), .FIFO_DEPTH(4),
                       .WR_HOLD(2), .TIMEOUT(80)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_wmask(sram_wmask),
        .sram_csb(sram_csb), .sram_we(sram_we), .sram_dout(sram_dout),
        .sram_data_ready(sram_data_ready));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wrapper stand-in: masked writes while csb/we low, read data after `lat` RD cycles.
    logic [31:0] mem [512];
    logic        m_dready = 0;
    logic [31:0] m_dout = 0;
    int          m_cnt = 0;
    int          lat = 2;
    bit          stub = 0;
    logic        spur = 0;
    assign sram_dout       = m_dout;
    assign sram_data_ready = m_dready | spur;

    always @(posedge clk) begin
        if (!sram_csb && !sram_we)
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        if (m_dready) m_dready <= 0;
        else if (!sram_csb && sram_we && !stub) begin
            if (m_cnt == lat - 1) begin
                m_dready <= 1;
                m_dout   <= mem[sram_addr];
            end
            m_cnt <= m_cnt + 1;
        end else m_cnt <= 0;
    end

    typedef struct { logic [8:0] a; logic [31:0] d; logic [3:0] m; } wr_t;
    typedef struct { logic [31:0] d; logic e; } rsp_t;
    wr_t  exp_wq[$];
    rsp_t exp_rq[$];

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_rq.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                rsp_t r;
                r = exp_rq.pop_front();
                chk("rsp_rdata", rsp_rdata, r.d);
                chk("rsp_err", rsp_err, r.e);
            end
        end
    end

    // SRAM-side protocol monitor and write scoreboard
    logic        prev_csb = 1, s_we = 1;
    int          low_len = 0, idle_len = 100;
    logic [8:0]  s_addr, p_addr;
    logic [31:0] s_din, p_din;
    logic [3:0]  s_mask, p_mask;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_csb = 1; low_len = 0; idle_len = 100;
        end else begin
            if (!sram_csb) begin
                if (prev_csb) begin
                    chk("idle_gap_ge2", idle_len >= 2, 1);
                    chk("setup_stable", {sram_addr, sram_din, sram_wmask}, {p_addr, p_din, p_mask});
                    s_addr = sram_addr; s_din = sram_din; s_mask = sram_wmask; s_we = sram_we;
                    low_len = 0;
                    if (!sram_we) begin
                        if (exp_wq.size() == 0) chk("wr_unexpected", 1, 0);
                        else begin
                            wr_t w;
                            w = exp_wq.pop_front();
                            chk("wr_fields", {sram_addr, sram_din, sram_wmask}, {w.a, w.d, w.m});
                        end
                    end
                end else if ({sram_we, sram_addr, sram_din, sram_wmask} !== {s_we, s_addr, s_din, s_mask})
                    chk("access_stable", {sram_we, sram_addr, sram_din, sram_wmask}, {s_we, s_addr, s_din, s_mask});
                low_len++;
            end else begin
                if (!prev_csb) begin
                    if (!s_we) chk("wr_hold_len", low_len, 2);
                    chk("gap_stable", {sram_addr, sram_din, sram_wmask}, {s_addr, s_din, s_mask});
                    idle_len = 0;
                end
                idle_len++;
                p_addr = sram_addr; p_din = sram_din; p_mask = sram_wmask;
            end
            prev_csb = sram_csb;
        end
    end

    task automatic push(input logic wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] m,
                        input bit exp_en, input logic [31:0] ed, input logic ee);
        int n = 0;
        @(negedge clk);
        req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
        while (!req_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("push_timeout", 1, 0);
        @(posedge clk);
        if (wr) exp_wq.push_back('{a: a, d: d, m: m});
        else if (exp_en) exp_rq.push_back('{d: ed, e: ee});
        #1 req_valid = 0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        push(1, a, d, m, 0, 0, 0);
    endtask

    task automatic rd(input logic [8:0] a, input logic [31:0] ed, input logic ee);
        push(0, a, 0, 0, 1, ed, ee);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rq.size() != 0 || exp_wq.size() != 0 || !sram_csb || rsp_valid) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("drain_in_time", n < 2000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rd();
        int n = 0;
        while (!(!sram_csb && sram_we) && n < 200) begin @(negedge clk); n++; end
        chk("reach_rd", n < 200, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_csb_we", {sram_csb, sram_we}, 2'b11);
        chk("rst_sram_bus", {sram_addr, sram_din, sram_wmask}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_req_ready", req_ready, 1);
        rst_n = 1;

        // data_ready outside RD must be ignored
        spur = 1;
        repeat (5) @(negedge clk);
        spur = 0;
        chk("spurious_ready", {rsp_valid, sram_csb}, 2'b01);

        // Basic writes and reads, including a partial byte mask
        wr(48, 77, 4'b1111);
        wr(49, 1, 4'b1111);
        rd(48, 77, 0);
        rd(49, 1, 0);
        wr(50, 32'hAABBCCDD, 4'b1111);
        wr(50, 32'h11223344, 4'b0101);
        rd(50, 32'hAA22CC44, 0);
        drain();

        // Response backpressure: second read must not start until the first handshakes
        rsp_ready = 0;
        rd(48, 77, 0);
        rd(49, 1, 0);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk("bp_first_rsp", rsp_valid, 1);
        n = 0;
        repeat (12) begin @(negedge clk); if (!sram_csb) n++; end
        chk("bp_blocked_csb_low_cycles", n, 0);
        chk("bp_held_rdata", rsp_rdata, 77);
        rsp_ready = 1;
        drain();

        // FIFO full while a slow read occupies the wrapper
        lat = 30;
        rd(48, 77, 0);
        for (int i = 0; i < 4; i++) wr(9'(60 + i), 32'h100 + i, 4'b1111);
        @(negedge clk);
        chk("full_req_ready", req_ready, 0);
        wr(64, 32'h104, 4'b1111);
        lat = 2;
        drain();
        rd(64, 32'h104, 0);
        rd(60, 32'h100, 0);
        drain();

        // Stuck wrapper
        stub = 1;
`ifdef SRAM_L1_REQ_TIMEOUT_EN
        rd(100, 0, 1);
        wait_rd();
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("timeout_rd_cycles", n, 80);
        drain();
        push(0, 100, 0, 0, 0, 0, 0);
`else
        push(0, 100, 0, 0, 0, 0, 0);
        wait_rd();
        repeat (210) @(negedge clk);
        chk("no_timeout_csb_low", {sram_csb, rsp_valid}, 2'b00);
`endif
        wait_rd();
        wr(48, 32'hDEAD, 4'b1111);   // queued behind the stuck read; must be flushed
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_csb", sram_csb, 1);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        exp_wq.delete();
        exp_rq.delete();
        stub = 0;
        @(negedge clk);
        #2 rst_n = 1;
        rd(48, 77, 0);
        drain();

        chk("queues_empty", {32'(exp_wq.size()), 32'(exp_rq.size())}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
